mux_sel_pipe: RTL and testbench

- Parametrised successor to the team's fixed 16-bit 4:1 operand mux.
- Selects one of CHANNELS input channels, each WIDTH bits, and forwards it to the ALU operand path through one registered output stage.
- All ports use valid/ready handshakes.
- Two select modes: explicit (sel-driven) and round-robin arbitration among valid channels.
- Sits between the register/immediate sources and the ALU operand input.

---
 rtl/alu_mux_pkg.sv | 19 +
 rtl/mux_sel_pipe_rr_arbiter.sv | 34 +++
 rtl/mux_sel_pipe.sv | 106 ++++++++++
 tb/tb_mux_sel_pipe.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_mux_pkg.sv
// Shared definitions for the ALU operand mux: select-mode encodings and
// the index-width helper used to size sel/out_chan.
package alu_mux_pkg;

  localparam logic MODE_EXPLICIT = 1'b0;
  localparam logic MODE_RR       = 1'b1;

  // Index width for n channels, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    if (n <= 2) begin
      r = 1;
    end else begin
      r = $clog2(n);
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_sel_pipe_rr_arbiter.sv
// Rotate-priority arbiter: the first requester after ptr (wrapping modulo N)
// wins. Purely combinational.
module rr_arbiter
  import alu_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          gnt_valid,
  output logic [PW-1:0] gnt_idx
);

  logic [PW-1:0] cand_s;

  // Walk ptr+1 .. ptr+N and keep the first requesting channel found.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand_s    = '0;
    for (int k = 1; k <= N; k++) begin
      cand_s = PW'((int'(ptr) + k) % N);
      if (!gnt_valid && req[cand_s]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_s;
      end else begin
        gnt_valid = gnt_valid;
        gnt_idx   = gnt_idx;
      end
    end
  end

endmodule

// File: rtl/mux_sel_pipe.sv
// Parametrised CHANNELS:1 operand mux with valid/ready on every port,
// explicit or round-robin selection and a single registered output stage.
module mux_sel_pipe
  import alu_mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = clog2_min1(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err
);

  logic             load_en_s;
  logic             sel_in_range_s;
  logic             rr_valid_s;
  logic [SEL_W-1:0] rr_idx_s;
  logic             gnt_valid_s;
  logic [SEL_W-1:0] gnt_idx_s;
  logic [SEL_W-1:0] rr_ptr_r;

  assign load_en_s = !out_valid || out_ready;

  rr_arbiter #(
    .N  (CHANNELS),
    .PW (SEL_W)
  ) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (rr_ptr_r),
    .gnt_valid (rr_valid_s),
    .gnt_idx   (rr_idx_s)
  );

  // Pick the grant source for this cycle from the current mode and sel.
  always_comb begin
    sel_in_range_s = (int'(sel) < CHANNELS);
    gnt_valid_s    = 1'b0;
    gnt_idx_s      = '0;
    if (mode == MODE_RR) begin
      gnt_valid_s = rr_valid_s;
      gnt_idx_s   = rr_idx_s;
    end else begin
      if (sel_in_range_s && in_valid[sel]) begin
        gnt_valid_s = 1'b1;
        gnt_idx_s   = sel;
      end else begin
        gnt_valid_s = 1'b0;
        gnt_idx_s   = '0;
      end
    end
  end

  // Accept from the granted channel only; nothing is accepted while in reset.
  always_comb begin
    in_ready = '0;
    if (rst_n && load_en_s && gnt_valid_s) begin
      in_ready[gnt_idx_s] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  // Output stage, round-robin pointer and sticky select-error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      sel_err   <= 1'b0;
      rr_ptr_r  <= SEL_W'(CHANNELS - 1);
    end else begin
      if (load_en_s) begin
        if (gnt_valid_s) begin
          out_data  <= in_data[gnt_idx_s*WIDTH +: WIDTH];
          out_chan  <= gnt_idx_s;
          out_valid <= 1'b1;
          if (mode == MODE_RR) begin
            rr_ptr_r <= gnt_idx_s;
          end else begin
            rr_ptr_r <= rr_ptr_r;
          end
        end else begin
          out_valid <= 1'b0;
        end
      end else begin
        out_valid <= out_valid;
      end
      if ((mode == MODE_EXPLICIT) && load_en_s && !sel_in_range_s) begin
        sel_err <= 1'b1;
      end else begin
        sel_err <= sel_err;
      end
    end
  end

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Directed testbench for mux_sel_pipe: a 4-channel instance for the main
// function and a 3-channel instance for the out-of-range select case.
module tb_mux_sel_pipe;

  logic        clk = 1'b0;
  logic        rst_n;

  // 4-channel instance
  logic [31:0] d4_in_data;
  logic [3:0]  d4_in_valid;
  logic [3:0]  d4_in_ready;
  logic        d4_mode;
  logic [1:0]  d4_sel;
  logic [7:0]  d4_out_data;
  logic [1:0]  d4_out_chan;
  logic        d4_out_valid;
  logic        d4_out_ready;
  logic        d4_sel_err;

  // 3-channel instance
  logic [23:0] d3_in_data;
  logic [2:0]  d3_in_valid;
  logic [2:0]  d3_in_ready;
  logic        d3_mode;
  logic [1:0]  d3_sel;
  logic [7:0]  d3_out_data;
  logic [1:0]  d3_out_chan;
  logic        d3_out_valid;
  logic        d3_out_ready;
  logic        d3_sel_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_sel_pipe #(.WIDTH(8), .CHANNELS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4_in_data), .in_valid(d4_in_valid),
    .in_ready(d4_in_ready), .mode(d4_mode), .sel(d4_sel),
    .out_data(d4_out_data), .out_chan(d4_out_chan), .out_valid(d4_out_valid),
    .out_ready(d4_out_ready), .sel_err(d4_sel_err)
  );

  mux_sel_pipe #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3_in_data), .in_valid(d3_in_valid),
    .in_ready(d3_in_ready), .mode(d3_mode), .sel(d3_sel),
    .out_data(d3_out_data), .out_chan(d3_out_chan), .out_valid(d3_out_valid),
    .out_ready(d3_out_ready), .sel_err(d3_sel_err)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check one registered word of the 4-channel instance.
  task automatic check_out4(input string tag, input logic [1:0] chan, input logic [7:0] data);
    check_val({tag, "_valid"}, 32'(d4_out_valid), 32'd1);
    check_val({tag, "_chan"},  32'(d4_out_chan),  32'(chan));
    check_val({tag, "_data"},  32'(d4_out_data),  32'(data));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_chan [6];
    logic [7:0] exp_data [4];
    logic [1:0] exp_chan2 [4];
    exp_data = '{8'h11, 8'h22, 8'hA5, 8'h44};

    rst_n        = 1'b0;
    d4_in_data   = {8'h44, 8'hA5, 8'h22, 8'h11};
    d4_in_valid  = 4'b1111;
    d4_mode      = 1'b0;
    d4_sel       = 2'd2;
    d4_out_ready = 1'b1;
    d3_in_data   = {8'hC3, 8'hB2, 8'hA1};
    d3_in_valid  = 3'b000;
    d3_mode      = 1'b0;
    d3_sel       = 2'd0;
    d3_out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check_val("rst_in_ready", 32'(d4_in_ready), 32'd0);
    check_val("rst_out_valid", 32'(d4_out_valid), 32'd0);
    check_val("rst_out_data", 32'(d4_out_data), 32'd0);
    check_val("rst_out_chan", 32'(d4_out_chan), 32'd0);
    check_val("rst_sel_err", 32'(d4_sel_err), 32'd0);

    // 1. Explicit select of channel 2
    rst_n = 1'b1;
    #1;
    check_val("t1_in_ready", 32'(d4_in_ready), 32'h4);
    tick();
    check_out4("t1_out", 2'd2, 8'hA5);

    // 2. Backpressure: stalled word holds, nothing accepted
    d4_out_ready = 1'b0;
    d4_in_data   = {8'h44, 8'h5A, 8'h22, 8'h11};
    #1;
    check_val("t2_in_ready_stall", 32'(d4_in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out4("t2_hold", 2'd2, 8'hA5);
      check_val("t2_in_ready_hold", 32'(d4_in_ready), 32'd0);
    end
    d4_out_ready = 1'b1;
    #1;
    check_val("t2_in_ready_release", 32'(d4_in_ready), 32'h4);
    tick();
    check_out4("t2_no_bubble", 2'd2, 8'h5A);

    // 3. Round-robin fairness, all channels valid
    d4_in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    d4_mode    = 1'b1;
    exp_chan   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 6; i++) begin
      tick();
      check_out4("t3_rr_all", exp_chan[i], exp_data[exp_chan[i]]);
    end
    // Channel 1 drops out
    d4_in_valid = 4'b1101;
    exp_chan2   = '{2'd2, 2'd3, 2'd0, 2'd2};
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out4("t3_rr_skip1", exp_chan2[i], exp_data[exp_chan2[i]]);
    end

    // 4. Sparse requests across the wrap: move pointer to 3, then ch0/ch3
    d4_in_valid = 4'b1000;
    tick();
    check_out4("t4_set_ptr", 2'd3, 8'h44);
    d4_in_valid = 4'b1001;
    tick();
    check_out4("t4_wrap_first", 2'd0, 8'h11);
    tick();
    check_out4("t4_wrap_second", 2'd3, 8'h44);
    // No requests: output empties, data/chan keep old values
    d4_in_valid = 4'b0000;
    #1;
    check_val("t4_idle_in_ready", 32'(d4_in_ready), 32'd0);
    tick();
    check_val("t4_idle_valid", 32'(d4_out_valid), 32'd0);
    check_val("t4_idle_chan", 32'(d4_out_chan), 32'd3);
    check_val("t4_idle_data", 32'(d4_out_data), 32'h44);

    // 6. Reset mid-stream with a stalled word and pointer at ch1
    d4_in_valid = 4'b1111;
    tick();
    check_out4("t6_pre0", 2'd0, 8'h11);
    tick();
    check_out4("t6_pre1", 2'd1, 8'h22);
    d4_out_ready = 1'b0;
    rst_n        = 1'b0;
    #1;
    check_val("t6_rst_in_ready", 32'(d4_in_ready), 32'd0);
    tick();
    check_val("t6_rst_valid", 32'(d4_out_valid), 32'd0);
    check_val("t6_rst_data", 32'(d4_out_data), 32'd0);
    check_val("t6_rst_sel_err", 32'(d4_sel_err), 32'd0);
    rst_n        = 1'b1;
    d4_out_ready = 1'b1;
    tick();
    check_out4("t6_restart", 2'd0, 8'h11);
    check_val("t6_d4_no_err", 32'(d4_sel_err), 32'd0);

    // 5. Out-of-range explicit select on the 3-channel instance
    d3_in_valid = 3'b111;
    d3_sel      = 2'd1;
    tick();
    check_val("t5_pre_valid", 32'(d3_out_valid), 32'd1);
    check_val("t5_pre_data", 32'(d3_out_data), 32'hB2);
    check_val("t5_pre_err", 32'(d3_sel_err), 32'd0);
    d3_sel = 2'd3;
    #1;
    check_val("t5_bad_in_ready", 32'(d3_in_ready), 32'd0);
    tick();
    check_val("t5_bad_valid", 32'(d3_out_valid), 32'd0);
    check_val("t5_bad_err", 32'(d3_sel_err), 32'd1);
    check_val("t5_bad_data_kept", 32'(d3_out_data), 32'hB2);
    d3_sel = 2'd0;
    tick();
    check_val("t5_recover_valid", 32'(d3_out_valid), 32'd1);
    check_val("t5_recover_data", 32'(d3_out_data), 32'hA1);
    check_val("t5_err_sticky", 32'(d3_sel_err), 32'd1);
    rst_n = 1'b0;
    tick();
    check_val("t5_err_cleared", 32'(d3_sel_err), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
